multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter MEM_HS, default 1, meaning 1 = memory states wait for mem_ack and 0 = each memory state lasts exactly one cycle.
REQ-002 SHALL have parameter OP_W, default 6, meaning opcode width.
REQ-003 SHALL have parameter FUNCT_W, default 6, meaning funct field width.
REQ-004 SHALL have ports: clk input 1 (sole clock, rising edge); rst_n input 1 (asynchronous, active-low reset).
REQ-005 SHALL have ports: op_c input OP_W (instruction opcode from IR); funct input FUNCT_W (R-type funct); zero input 1 (ALU zero flag); mem_ack input 1 (memory transfer done).
REQ-006 SHALL have ports: mem_req output 1 (memory access request); mem_we output 1 (memory write); iord output 1 (0 = PC address, 1 = ALU-out address); ir_we output 1 (IR load); pc_we output 1 (PC load).
REQ-007 SHALL have ports: argA_c output 1 (0 = PC, 1 = reg A); argB_c output 2 (00 reg B, 01 const 4, 10 ext imm, 11 ext imm<<2); aluop output 2 (00 add, 01 sub, 10 funct-decoded); ext_c output 1 (1 = LUI upper placement).
REQ-008 SHALL have ports: dest_reg_c output 1 (1 = rt, 0 = rd); we_c output 1 (regfile write); result_c output 2 (00 ALU, 01 memory data, 10 shifter, 11 shift-by-variable); sh_d_c output 1 (shift direction, 1 = left); pc_src output 2 (00 ALU, 01 ALU-out, 10 jump target).
REQ-009 SHALL have ports: state output 4 (current state code); illegal output 1 (unknown-opcode pulse).

Function
REQ-010 SHALL implement Moore FSM states and codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BEQ 8, IMMEX 9, IMMWB 10, JUMP 11, TRAP 12.
REQ-011 SHALL drive all outputs to 0 in any state except where REQ-012..REQ-020 assert them; codes 13-15 SHALL go to FETCH next cycle.
REQ-012 FETCH: mem_req=1, iord=0, argB_c=01, aluop=00, pc_src=00; ir_we=pc_we=1 only in the cycle mem_ack=1 (MEM_HS=1) or unconditionally (MEM_HS=0); advance to DECODE on that cycle, else hold.
REQ-013 DECODE: argB_c=11, aluop=00 (branch target precompute); next by op_c: LW/SW->MEMADR, RTYPE->EXEC, BEQ->BEQ, ADDI/ORI/LUI->IMMEX, J->JUMP, other->TRAP.
REQ-014 MEMADR: argA_c=1, argB_c=10, aluop=00; next MEMRD for LW, MEMWR for SW.
REQ-015 MEMRD: mem_req=1, iord=1; advance to MEMWB on handshake per REQ-012 rule. MEMWB: we_c=1, dest_reg_c=1, result_c=01; next FETCH.
REQ-016 MEMWR: mem_req=1, mem_we=1, iord=1; advance to FETCH on handshake per REQ-012 rule.
REQ-017 EXEC: argA_c=1, argB_c=00, aluop=10; next ALUWB. ALUWB: we_c=1, dest_reg_c=0; SLL funct -> result_c=10, sh_d_c=1; SRL funct -> result_c=10, sh_d_c=0; else result_c=00; next FETCH.
REQ-018 BEQ: argA_c=1, argB_c=00, aluop=01, pc_src=01, pc_we=zero; next FETCH.
REQ-019 IMMEX: argA_c=1, argB_c=10; aluop=10 for ORI else 00; ext_c=1 for LUI; next IMMWB. IMMWB: we_c=1, dest_reg_c=1, result_c=00; next FETCH.
REQ-020 JUMP: pc_src=10, pc_we=1; next FETCH. TRAP: illegal=1 for exactly one cycle; next FETCH.
REQ-021 mem_ack SHALL be ignored in any state with mem_req=0.
REQ-022 Decoding in DECODE/ALUWB/IMMEX SHALL use op_c/funct sampled combinationally in that cycle; the IR is stable outside FETCH.

Reset
REQ-023 rst_n=0 SHALL asynchronously force state to FETCH; all registered state cleared, including mid-wait in FETCH/MEMRD/MEMWR.
REQ-024 Output values after reset SHALL be FETCH Moore values: mem_req=1, argB_c=01, all others 0 (ir_we/pc_we follow mem_ack when MEM_HS=1).

Structure
REQ-025 Opcode/funct constants (RTYPE, LW, SW, J, BEQ, ADDI, LUI, ORI, SLL, SRL) and the state encoding SHALL live in the shared funct_codes include/package.
REQ-026 SHALL be split into an FSM register/next-state section and a combinational output decoder; no sub-module required.

Verification
REQ-027 LW, MEM_HS=1, mem_ack delayed 3 cycles in FETCH and 2 in MEMRD -> state sequence 0,0,0,0,1,2,3,3,3,4,0; we_c=1, result_c=01 only in MEMWB.
REQ-028 BEQ with zero=1 then zero=0 -> pc_we=1 with pc_src=01 in BEQ state first case, pc_we=0 second; both return to FETCH.
REQ-029 RTYPE funct=SLL -> ALUWB shows result_c=10, sh_d_c=1, dest_reg_c=0; funct=ADD -> result_c=00.
REQ-030 op_c=6'b111111 -> DECODE->TRAP, illegal high exactly one cycle, then FETCH.
REQ-031 rst_n low asynchronously during MEMWR wait -> state=0 immediately without clock, mem_we=0; after release fetch restarts.
REQ-032 MEM_HS=0, ADDI -> sequence 0,1,9,10,0 with mem_ack held 0 throughout.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS-style controller.
// Holds the state encoding, the opcode/funct constants decoded by the
// controller, and the field codes used on the datapath select outputs.
package multicycle_ctrl_pkg;

  // State codes are visible on the state output, so the values are fixed.
  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBeq    = 4'd8,
    StImmEx  = 4'd9,
    StImmWb  = 4'd10,
    StJump   = 4'd11,
    StTrap   = 4'd12
  } state_e;

  // Opcodes (instruction bits 31:26).
  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpOri   = 6'h0d;
  localparam logic [5:0] OpLui   = 6'h0f;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2b;

  // R-type funct codes that need the shifter on writeback.
  localparam logic [5:0] FnSll   = 6'h00;
  localparam logic [5:0] FnSrl   = 6'h02;

  // ALU operand B select.
  localparam logic [1:0] ArgBRegB   = 2'b00;
  localparam logic [1:0] ArgBConst4 = 2'b01;
  localparam logic [1:0] ArgBImm    = 2'b10;
  localparam logic [1:0] ArgBImmSh2 = 2'b11;

  // ALU operation class.
  localparam logic [1:0] AluAdd   = 2'b00;
  localparam logic [1:0] AluSub   = 2'b01;
  localparam logic [1:0] AluFunct = 2'b10;

  // Register file write data select.
  localparam logic [1:0] ResAlu      = 2'b00;
  localparam logic [1:0] ResMem      = 2'b01;
  localparam logic [1:0] ResShift    = 2'b10;
  localparam logic [1:0] ResShiftVar = 2'b11;

  // PC source select.
  localparam logic [1:0] PcAlu    = 2'b00;
  localparam logic [1:0] PcAluOut = 2'b01;
  localparam logic [1:0] PcJump   = 2'b10;

  // States that drive a memory request and therefore wait on the handshake.
  function automatic logic is_mem_state(state_e s);
    return (s == StFetch) || (s == StMemRd) || (s == StMemWr);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_dec.sv
// Combinational Moore output decoder for multicycle_ctrl.
// Ports:
//   i_state       current FSM state
//   i_op, i_funct IR opcode / funct, read combinationally in EXEC-side states
//   i_zero        ALU zero flag (gates the branch PC write)
//   i_mem_done    memory phase completes this cycle (ack or no-handshake)
//   o_*           datapath controls, see multicycle_ctrl for meanings
module multicycle_ctrl_dec
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned OP_W    = 6,
  parameter int unsigned FUNCT_W = 6
) (
  input  state_e             i_state,
  input  logic [OP_W-1:0]    i_op,
  input  logic [FUNCT_W-1:0] i_funct,
  input  logic               i_zero,
  input  logic               i_mem_done,
  output logic               o_mem_req,
  output logic               o_mem_we,
  output logic               o_iord,
  output logic               o_ir_we,
  output logic               o_pc_we,
  output logic               o_arga_c,
  output logic [1:0]         o_argb_c,
  output logic [1:0]         o_aluop,
  output logic               o_ext_c,
  output logic               o_dest_reg_c,
  output logic               o_we_c,
  output logic [1:0]         o_result_c,
  output logic               o_sh_d_c,
  output logic [1:0]         o_pc_src,
  output logic               o_illegal
);

  logic w_is_ori;
  logic w_is_lui;
  logic w_is_sll;
  logic w_is_srl;

  assign w_is_ori = (i_op == OP_W'(OpOri));
  assign w_is_lui = (i_op == OP_W'(OpLui));
  assign w_is_sll = (i_funct == FUNCT_W'(FnSll));
  assign w_is_srl = (i_funct == FUNCT_W'(FnSrl));

  always_comb begin
    o_mem_req    = 1'b0;
    o_mem_we     = 1'b0;
    o_iord       = 1'b0;
    o_ir_we      = 1'b0;
    o_pc_we      = 1'b0;
    o_arga_c     = 1'b0;
    o_argb_c     = ArgBRegB;
    o_aluop      = AluAdd;
    o_ext_c      = 1'b0;
    o_dest_reg_c = 1'b0;
    o_we_c       = 1'b0;
    o_result_c   = ResAlu;
    o_sh_d_c     = 1'b0;
    o_pc_src     = PcAlu;
    o_illegal    = 1'b0;

    case (i_state)
      StFetch: begin
        // PC+4 is computed while the instruction is read; both land together.
        o_mem_req = 1'b1;
        o_argb_c  = ArgBConst4;
        o_ir_we   = i_mem_done;
        o_pc_we   = i_mem_done;
      end
      StDecode: begin
        // Branch target precomputed into ALU-out for a possible BEQ.
        o_argb_c = ArgBImmSh2;
      end
      StMemAdr: begin
        o_arga_c = 1'b1;
        o_argb_c = ArgBImm;
      end
      StMemRd: begin
        o_mem_req = 1'b1;
        o_iord    = 1'b1;
      end
      StMemWb: begin
        o_we_c       = 1'b1;
        o_dest_reg_c = 1'b1;
        o_result_c   = ResMem;
      end
      StMemWr: begin
        o_mem_req = 1'b1;
        o_mem_we  = 1'b1;
        o_iord    = 1'b1;
      end
      StExec: begin
        o_arga_c = 1'b1;
        o_aluop  = AluFunct;
      end
      StAluWb: begin
        o_we_c = 1'b1;
        if (w_is_sll) begin
          o_result_c = ResShift;
          o_sh_d_c   = 1'b1;
        end else if (w_is_srl) begin
          o_result_c = ResShift;
        end
      end
      StBeq: begin
        o_arga_c = 1'b1;
        o_aluop  = AluSub;
        o_pc_src = PcAluOut;
        o_pc_we  = i_zero;
      end
      StImmEx: begin
        o_arga_c = 1'b1;
        o_argb_c = ArgBImm;
        o_aluop  = w_is_ori ? AluFunct : AluAdd;
        o_ext_c  = w_is_lui;
      end
      StImmWb: begin
        o_we_c       = 1'b1;
        o_dest_reg_c = 1'b1;
      end
      StJump: begin
        o_pc_src = PcJump;
        o_pc_we  = 1'b1;
      end
      StTrap: begin
        o_illegal = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control unit (Moore FSM).
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   op_c, funct           IR opcode and R-type funct
//   zero                  ALU zero flag
//   mem_ack               memory transfer done (used only while mem_req=1)
//   mem_req/mem_we/iord   memory request, write strobe, address select
//   ir_we/pc_we           IR and PC load enables
//   argA_c/argB_c/aluop   ALU operand and operation selects
//   ext_c                 LUI upper-half immediate placement
//   dest_reg_c/we_c       regfile destination select and write enable
//   result_c/sh_d_c       writeback source and shift direction
//   pc_src                PC source select
//   state                 current state code
//   illegal               one-cycle pulse on an unknown opcode
// MEM_HS=1 makes memory states wait for mem_ack; MEM_HS=0 makes them one cycle.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned MEM_HS  = 1,
  parameter int unsigned OP_W    = 6,
  parameter int unsigned FUNCT_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OP_W-1:0]    op_c,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               zero,
  input  logic               mem_ack,
  output logic               mem_req,
  output logic               mem_we,
  output logic               iord,
  output logic               ir_we,
  output logic               pc_we,
  output logic               argA_c,
  output logic [1:0]         argB_c,
  output logic [1:0]         aluop,
  output logic               ext_c,
  output logic               dest_reg_c,
  output logic               we_c,
  output logic [1:0]         result_c,
  output logic               sh_d_c,
  output logic [1:0]         pc_src,
  output logic [3:0]         state,
  output logic               illegal
);

  state_e r_state;
  state_e w_state_nxt;
  logic   w_mem_done;

  // mem_ack is qualified by the state so it has no effect outside memory states.
  assign w_mem_done = is_mem_state(r_state) & ((MEM_HS != 0) ? mem_ack : 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StFetch;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = StFetch;
    case (r_state)
      StFetch:  w_state_nxt = w_mem_done ? StDecode : StFetch;
      StDecode: begin
        case (op_c)
          OP_W'(OpLw), OP_W'(OpSw):                 w_state_nxt = StMemAdr;
          OP_W'(OpRtype):                           w_state_nxt = StExec;
          OP_W'(OpBeq):                             w_state_nxt = StBeq;
          OP_W'(OpAddi), OP_W'(OpOri), OP_W'(OpLui): w_state_nxt = StImmEx;
          OP_W'(OpJ):                               w_state_nxt = StJump;
          default:                                  w_state_nxt = StTrap;
        endcase
      end
      // Only LW and SW reach MEMADR, so anything other than SW is a load.
      StMemAdr: w_state_nxt = (op_c == OP_W'(OpSw)) ? StMemWr : StMemRd;
      StMemRd:  w_state_nxt = w_mem_done ? StMemWb : StMemRd;
      StMemWb:  w_state_nxt = StFetch;
      StMemWr:  w_state_nxt = w_mem_done ? StFetch : StMemWr;
      StExec:   w_state_nxt = StAluWb;
      StImmEx:  w_state_nxt = StImmWb;
      // ALUWB, BEQ, IMMWB, JUMP, TRAP and unused codes all return to fetch.
      default:  w_state_nxt = StFetch;
    endcase
  end

  assign state = r_state;

  multicycle_ctrl_dec #(
    .OP_W    (OP_W),
    .FUNCT_W (FUNCT_W)
  ) u_dec (
    .i_state      (r_state),
    .i_op         (op_c),
    .i_funct      (funct),
    .i_zero       (zero),
    .i_mem_done   (w_mem_done),
    .o_mem_req    (mem_req),
    .o_mem_we     (mem_we),
    .o_iord       (iord),
    .o_ir_we      (ir_we),
    .o_pc_we      (pc_we),
    .o_arga_c     (argA_c),
    .o_argb_c     (argB_c),
    .o_aluop      (aluop),
    .o_ext_c      (ext_c),
    .o_dest_reg_c (dest_reg_c),
    .o_we_c       (we_c),
    .o_result_c   (result_c),
    .o_sh_d_c     (sh_d_c),
    .o_pc_src     (pc_src),
    .o_illegal    (illegal)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl. A reference model expands each
// instruction into its expected per-cycle state/output trace, which is then
// replayed against the DUT with randomized opcodes, funct, zero and ack delays.
module tb_multicycle_ctrl;

  localparam logic [5:0] LW = 6'h23, SW = 6'h2b, RT = 6'h00, BQ = 6'h04;
  localparam logic [5:0] AI = 6'h08, OI = 6'h0d, LI = 6'h0f, JJ = 6'h02;
  localparam logic [5:0] SLL = 6'h00, SRL = 6'h02, ADD = 6'h20;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_we;
    logic       pc_we;
    logic       arga;
    logic [1:0] argb;
    logic [1:0] aluop;
    logic       ext;
    logic       dest;
    logic       we;
    logic [1:0] result;
    logic       shd;
    logic [1:0] pc_src;
    logic       illegal;
  } out_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op_c = 6'h00;
  logic [5:0] funct = 6'h00;
  logic       zero = 1'b0;
  logic       mem_ack = 1'b0;

  logic mem_req, mem_we, iord, ir_we, pc_we, arga, ext, dest, we, shd, illegal;
  logic [1:0] argb, aluop, result, pc_src;
  logic [3:0] state;

  logic h_mem_req, h_mem_we, h_iord, h_ir_we, h_pc_we, h_arga, h_ext, h_dest, h_we, h_shd;
  logic h_illegal;
  logic [1:0] h_argb, h_aluop, h_result, h_pc_src;
  logic [3:0] h_state;

  out_t w_got;
  assign w_got = {mem_req, mem_we, iord, ir_we, pc_we, arga, argb, aluop, ext, dest, we,
                  result, shd, pc_src, illegal};

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_HS(1), .OP_W(6), .FUNCT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .op_c(op_c), .funct(funct), .zero(zero), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_we(ir_we), .pc_we(pc_we),
    .argA_c(arga), .argB_c(argb), .aluop(aluop), .ext_c(ext), .dest_reg_c(dest),
    .we_c(we), .result_c(result), .sh_d_c(shd), .pc_src(pc_src), .state(state),
    .illegal(illegal)
  );

  multicycle_ctrl #(.MEM_HS(0), .OP_W(6), .FUNCT_W(6)) dut_nohs (
    .clk(clk), .rst_n(rst_n), .op_c(op_c), .funct(funct), .zero(zero), .mem_ack(mem_ack),
    .mem_req(h_mem_req), .mem_we(h_mem_we), .iord(h_iord), .ir_we(h_ir_we),
    .pc_we(h_pc_we), .argA_c(h_arga), .argB_c(h_argb), .aluop(h_aluop), .ext_c(h_ext),
    .dest_reg_c(h_dest), .we_c(h_we), .result_c(h_result), .sh_d_c(h_shd),
    .pc_src(h_pc_src), .state(h_state), .illegal(h_illegal)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int   q_st[$];
  out_t q_out[$];
  bit   q_ack[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit rnd();
    return 1'($urandom % 2);
  endfunction

  task automatic push(input int st, input out_t o, input bit ack);
    q_st.push_back(st);
    q_out.push_back(o);
    q_ack.push_back(ack);
  endtask

  // Expected trace of one instruction, from FETCH to its last state.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int df, input int dm);
    out_t o;
    int   mst;
    o = '0; o.mem_req = 1'b1; o.argb = 2'b01;
    for (int i = 0; i < df; i++) push(0, o, 1'b0);
    o.ir_we = 1'b1; o.pc_we = 1'b1;
    push(0, o, 1'b1);
    o = '0; o.argb = 2'b11;
    push(1, o, rnd());
    case (op)
      LW, SW: begin
        o = '0; o.arga = 1'b1; o.argb = 2'b10;
        push(2, o, rnd());
        mst = (op == SW) ? 5 : 3;
        o = '0; o.mem_req = 1'b1; o.iord = 1'b1; o.mem_we = (op == SW);
        for (int i = 0; i < dm; i++) push(mst, o, 1'b0);
        push(mst, o, 1'b1);
        if (op == LW) begin
          o = '0; o.we = 1'b1; o.dest = 1'b1; o.result = 2'b01;
          push(4, o, rnd());
        end
      end
      RT: begin
        o = '0; o.arga = 1'b1; o.aluop = 2'b10;
        push(6, o, rnd());
        o = '0; o.we = 1'b1;
        if (fn == SLL) begin o.result = 2'b10; o.shd = 1'b1; end
        else if (fn == SRL) o.result = 2'b10;
        push(7, o, rnd());
      end
      BQ: begin
        o = '0; o.arga = 1'b1; o.aluop = 2'b01; o.pc_src = 2'b01; o.pc_we = z;
        push(8, o, rnd());
      end
      AI, OI, LI: begin
        o = '0; o.arga = 1'b1; o.argb = 2'b10;
        o.aluop = (op == OI) ? 2'b10 : 2'b00;
        o.ext = (op == LI);
        push(9, o, rnd());
        o = '0; o.we = 1'b1; o.dest = 1'b1;
        push(10, o, rnd());
      end
      JJ: begin
        o = '0; o.pc_src = 2'b10; o.pc_we = 1'b1;
        push(11, o, rnd());
      end
      default: begin
        o = '0; o.illegal = 1'b1;
        push(12, o, rnd());
      end
    endcase
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int df, input int dm);
    int   st;
    out_t o;
    bit   a;
    build(op, fn, z, df, dm);
    while (q_st.size() > 0) begin
      st = q_st.pop_front();
      o  = q_out.pop_front();
      a  = q_ack.pop_front();
      @(negedge clk);
      op_c = op; funct = fn; zero = z; mem_ack = a;
      #1;
      cyc++;
      check_eq($sformatf("state c%0d op%0h", cyc, op), 32'(state), 32'(st));
      check_eq($sformatf("outs c%0d st%0d op%0h", cyc, st, op), 32'(w_got), 32'(o));
    end
  endtask

  initial begin
    logic [5:0] ops[9];
    logic [5:0] op, fn;
    int         exp_nohs[4];
    out_t       o;

    ops = '{LW, SW, RT, BQ, AI, OI, LI, JJ, 6'h3f};

    // Reset values: FETCH Moore outputs, ir_we/pc_we following mem_ack.
    #2;
    o = '0; o.mem_req = 1'b1; o.argb = 2'b01;
    check_eq("reset_state", 32'(state), 32'd0);
    check_eq("reset_outs", 32'(w_got), 32'(o));
    mem_ack = 1'b1;
    #1;
    o.ir_we = 1'b1; o.pc_we = 1'b1;
    check_eq("reset_outs_ack", 32'(w_got), 32'(o));
    mem_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases first, then randomized traffic.
    run_instr(LW, ADD, 1'b0, 3, 2);
    run_instr(BQ, ADD, 1'b1, 0, 0);
    run_instr(BQ, ADD, 1'b0, 0, 0);
    run_instr(RT, SLL, 1'b0, 1, 0);
    run_instr(RT, ADD, 1'b0, 0, 0);
    run_instr(RT, SRL, 1'b1, 0, 0);
    run_instr(6'h3f, ADD, 1'b0, 0, 0);
    run_instr(AI, ADD, 1'b0, 0, 0);
    run_instr(OI, ADD, 1'b0, 2, 0);
    run_instr(LI, ADD, 1'b0, 0, 0);
    run_instr(JJ, ADD, 1'b0, 0, 0);
    run_instr(SW, ADD, 1'b0, 1, 3);

    for (int k = 0; k < 150; k++) begin
      int sel;
      sel = int'($urandom % 10);
      if (sel < 9) op = ops[sel];
      else op = 6'($urandom % 64);
      case ($urandom % 4)
        0: fn = SLL;
        1: fn = SRL;
        2: fn = ADD;
        default: fn = 6'($urandom % 64);
      endcase
      run_instr(op, fn, rnd(), int'($urandom % 4), int'($urandom % 4));
    end

    // Asynchronous reset while MEMWR waits for its ack.
    @(negedge clk); op_c = SW; mem_ack = 1'b1;
    @(negedge clk); mem_ack = 1'b0; #1;
    check_eq("sw_decode", 32'(state), 32'd1);
    @(negedge clk); #1;
    check_eq("sw_memadr", 32'(state), 32'd2);
    @(negedge clk); #1;
    check_eq("sw_memwr", 32'(state), 32'd5);
    check_eq("sw_memwr_we", 32'(mem_we), 32'd1);
    @(negedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_eq("arst_state", 32'(state), 32'd0);
    check_eq("arst_mem_we", 32'(mem_we), 32'd0);
    check_eq("arst_mem_req", 32'(mem_req), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_instr(LW, ADD, 1'b0, 1, 1);

    // No-handshake variant: ADDI runs straight through with mem_ack low.
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1; op_c = AI; funct = ADD; mem_ack = 1'b0; #1;
    check_eq("nohs_fetch", 32'(h_state), 32'd0);
    check_eq("nohs_ir_we", 32'(h_ir_we), 32'd1);
    exp_nohs = '{1, 9, 10, 0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      check_eq($sformatf("nohs_seq%0d", i), 32'(h_state), 32'(exp_nohs[i]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
